// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package ifetch_pkg;

  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
  localparam int          IMEM_LATENCY    = 1;
  localparam int          FIFO_DEPTH      = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Two-entry in-order buffer between the ROM response and decode.
// Head is always entry 0; flush empties it in one cycle.
module ifetch_skid_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem [FIFO_DEPTH];
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) mem[0] <= din;
          else               mem[1] <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new entry lands behind whatever remains
          if (cnt_q == 2'd1) begin
            mem[0] <= din;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC, 1-cycle ROM, 2-entry skid buffer to decode.
// Define IFETCH_PERF_EN to add perf_fetched / perf_stall counters.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         req_q;
  logic         pop;
  logic         push;
  logic         issue;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_din;
  fetch_entry_t fifo_head;

  assign imem_addr = pc_q[31:2];
  assign pop       = dec_valid && dec_ready;
  assign push      = req_q && !redirect_valid;
  assign fifo_din  = '{pc: req_pc_q, inst: imem_inst};

  // Issue only if the slot can still be absorbed: occupancy + in-flight - pop < 2
  always_comb begin
    issue = 1'b0;
    if (!redirect_valid) begin
      if (fifo_empty)     issue = 1'b1;
      else if (fifo_full) issue = pop && !req_q;
      else                issue = !req_q || pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= word_align(RESET_PC);
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q  <= word_align(redirect_pc);
      req_q <= 1'b0;
    end else if (issue) begin
      pc_q     <= pc_q + 32'd4;
      req_q    <= 1'b1;
      req_pc_q <= pc_q;
    end else begin
      req_q <= 1'b0;
    end
  end

  ifetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign dec_valid = !fifo_empty;
  assign dec_inst  = fifo_head.inst;
  assign dec_pc    = fifo_head.pc;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop)                     perf_fetched <= perf_fetched + 32'd1;
      if (dec_valid && !dec_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus random ready/redirect traffic
// checked against an in-order fetch-stream model.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h3c1d1000;
      30'd1:   return 32'h0c000003;
      30'd2:   return 32'h37bd4000;
      default: return {a, 2'b00} ^ 32'h5a5a_0f0f;
    endcase
  endfunction

  // registered-address ROM
  always @(posedge clk) imem_inst <= rom_word(imem_addr);

  int errors = 0;
  int checks = 0;

  // stream model state
  logic [31:0] exp_pc;
  int          since;
  logic        hold;
  logic [31:0] prev_pc, prev_inst;
  int          acc, stl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check the visible state against the model, advance.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (hold) begin
      chk("hold_valid", {31'd0, dec_valid}, 32'd1);
      chk("hold_pc", dec_pc, prev_pc);
      chk("hold_inst", dec_inst, prev_inst);
    end
    if (since == 1 || since == 2) chk("redir_gap", {31'd0, dec_valid}, 32'd0);
    if (since == 3)               chk("redir_lat", {31'd0, dec_valid}, 32'd1);
    if (dec_valid && rdy) begin
      chk("seq_pc", dec_pc, exp_pc);
      chk("seq_inst", dec_inst, rom_word(exp_pc[31:2]));
      exp_pc = exp_pc + 32'd4;
      acc++;
    end
    if (dec_valid && !rdy) stl++;
    if (rv) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
      since  = 0;
    end
    hold      = dec_valid && !rdy && !rv;
    prev_pc   = dec_pc;
    prev_inst = dec_inst;
    @(posedge clk); #1;
    if (since < 100) since++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_inst", dec_inst, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_addr", {2'b00, imem_addr}, RESET_PC >> 2);
    @(posedge clk); #1;
    rst    = 1'b0;
    exp_pc = RESET_PC;
    since  = 100;
    hold   = 1'b0;
    acc    = 0;
    stl    = 0;
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    since = 100; hold = 1'b0; exp_pc = RESET_PC; acc = 0; stl = 0;
    prev_pc = '0; prev_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // boot stream with decode always ready
    step(1, 0, 0); chk("boot_gap", {31'd0, dec_valid}, 32'd0);
    step(1, 0, 0); chk("boot_v", {31'd0, dec_valid}, 32'd1);
    chk("boot_pc0", dec_pc, 32'h0); chk("boot_i0", dec_inst, 32'h3c1d1000);
    step(1, 0, 0); chk("boot_pc4", dec_pc, 32'h4); chk("boot_i1", dec_inst, 32'h0c000003);
    step(1, 0, 0); chk("boot_pc8", dec_pc, 32'h8); chk("boot_i2", dec_inst, 32'h37bd4000);
    step(1, 0, 0); chk("pre_rst_v", {31'd0, dec_valid}, 32'd1);

    // reset mid-cycle while streaming
    #2;
    do_reset();

    // decode stalls right after first valid
    step(0, 0, 0); chk("st_gap", {31'd0, dec_valid}, 32'd0);
    step(0, 0, 0); chk("st_v", {31'd0, dec_valid}, 32'd1);
    repeat (5) step(0, 0, 0);
    chk("st_pc", dec_pc, 32'h0); chk("st_inst", dec_inst, 32'h3c1d1000);
    chk("st_addr", {2'b00, imem_addr}, 32'd2);
    step(1, 0, 0); chk("rel_v1", {31'd0, dec_valid}, 32'd1); chk("rel_pc4", dec_pc, 32'h4);
    step(1, 0, 0); chk("rel_v2", {31'd0, dec_valid}, 32'd1); chk("rel_pc8", dec_pc, 32'h8);
    step(1, 0, 0); chk("rel_pc12", dec_pc, 32'hc);

    // redirect with buffer full
    repeat (3) step(0, 0, 0);
    step(0, 1, 32'h14);
    chk("rd_gap0", {31'd0, dec_valid}, 32'd0);
    step(1, 0, 0); chk("rd_gap1", {31'd0, dec_valid}, 32'd0);
    step(1, 0, 0); chk("rd_v", {31'd0, dec_valid}, 32'd1);
    chk("rd_pc", dec_pc, 32'h14); chk("rd_inst", dec_inst, rom_word(30'd5));
    step(1, 0, 0); chk("rd_pc18", dec_pc, 32'h18);
    step(1, 0, 0);

    // redirect with handshake, unaligned target, then back-to-back redirects
    step(1, 1, 32'h0000_0103);
    step(1, 1, 32'h0000_0200);
    step(1, 1, 32'h0000_0300);
    step(1, 0, 0); step(1, 0, 0);
    chk("b2b_pc", dec_pc, 32'h300);
    step(1, 0, 0); chk("b2b_pc2", dec_pc, 32'h304);

    // address wrap
    step(1, 1, 32'hFFFF_FFFC);
    step(1, 0, 0); step(1, 0, 0);
    chk("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
    step(1, 0, 0); chk("wrap_pc1", dec_pc, 32'h0);
    step(1, 0, 0); chk("wrap_pc2", dec_pc, 32'h4);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(15) == 0, $urandom);
    chk("rnd_progress", {31'd0, (acc > 100)}, 32'd1);

    // counter scenario: 3 stall cycles then 10 accepts
    do_reset();
    step(0, 0, 0); step(0, 0, 0);
    repeat (3) step(0, 0, 0);
    repeat (10) step(1, 0, 0);
    chk("cnt_acc", acc, 32'd10);
    chk("cnt_stl", stl, 32'd3);
`ifdef IFETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
